score_argmax_unit: RTL and testbench
====================================

SCORE_ARGMAX_UNIT -- requirements
Module: score_argmax_unit

Interface
REQ-001 SHALL have parameter W, default 26, meaning score width (signed two's-complement fixed point, same format as adder-tree output).
REQ-002 SHALL have parameter NUM_CLASSES, default 10, meaning scores per frame (2..16).
REQ-003 SHALL have parameter TREE_LAT, default 8, meaning adder-tree latency in cycles from operand launch to Result_1 valid.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port GlobalReset, input, 1, meaning synchronous active-low reset.
REQ-006 SHALL have port InValid, input, 1, meaning a class's operands enter the adder tree this cycle.
REQ-007 SHALL have port Score, input, W, meaning adder-tree Result_1.
REQ-008 SHALL have port ClassIdx, output, 4, meaning index of the maximum score of the last completed frame.
REQ-009 SHALL have port MaxScore, output, W, meaning value of that maximum.
REQ-010 SHALL have port Done, output, 1, meaning one-cycle pulse when ClassIdx/MaxScore update.
REQ-011 SHALL have port Busy, output, 1, meaning a frame is partially received (state ACCUM).

Function
REQ-012 SHALL delay InValid through a TREE_LAT-deep shift register; its output ScoreValid qualifies Score.
REQ-013 SHALL accept any InValid pattern (back-to-back or gapped); each InValid maps to exactly one ScoreValid TREE_LAT cycles later.
REQ-014 SHALL implement FSM IDLE/ACCUM: IDLE->ACCUM on ScoreValid when NUM_CLASSES>1; ACCUM->IDLE on ScoreValid with count==NUM_CLASSES-1; otherwise hold.
REQ-015 SHALL keep a class counter: 0 on the frame's first ScoreValid, +1 per ScoreValid, and no wrap beyond NUM_CLASSES-1 (the frame closes there).
REQ-016 SHALL on the first score of a frame load running max = Score and running index = 0 unconditionally.
REQ-017 SHALL on later scores replace running max/index only if Score > running max (signed compare); ties keep the lower index.
REQ-018 SHALL on the last score of a frame register final index/max (including that score) into ClassIdx/MaxScore and assert Done in the cycle after that ScoreValid.
REQ-019 SHALL give latency last InValid -> Done = TREE_LAT+1 cycles.
REQ-020 SHALL hold ClassIdx/MaxScore stable between Done pulses.
REQ-021 SHALL treat a ScoreValid in the cycle Done is high as the first score of the next frame, with no lost cycle.
REQ-022 SHALL ignore Score when ScoreValid is low.

Reset
REQ-023 SHALL on GlobalReset low at a clock edge clear delay line, counter, running max/index, and FSM (to IDLE); ClassIdx=0, MaxScore=0, Done=0, Busy=0.
REQ-024 SHALL discard a partially received frame and all in-flight delay-line valids on reset mid-frame; Done does not pulse for it.

Structure
REQ-025 SHALL take W, NUM_CLASSES default, and index width from the shared project package alongside the adder-tree width constants.
REQ-026 SHALL build the delay line as one sub-module, valid_delay_line (param DEPTH), from the codebase's FF register cell.

Verification (NUM_CLASSES=10, TREE_LAT=8)
REQ-027 SHALL cover: 10 back-to-back InValid, scores 1..10 -> Done 9 cycles after last InValid, ClassIdx=9, MaxScore=10.
REQ-028 SHALL cover: scores all negative, -5 at class 3, others -100 -> ClassIdx=3, MaxScore=-5 (signed compare).
REQ-029 SHALL cover: tie, value 7 at classes 2 and 6, rest 0 -> ClassIdx=2.
REQ-030 SHALL cover: gapped InValid (one idle cycle between each), then next frame starting in Done cycle -> two Done pulses, correct results for both.
REQ-031 SHALL cover: reset asserted after 5 scores, then full frame with max at class 4 -> single Done, ClassIdx=4, no Done from aborted frame.

Source files
------------

// File: rtl/score_argmax_unit_pkg.sv
// Shared constants for the classifier back end: adder-tree widths, score format,
// class-index width and the argmax FSM state encoding.
package score_argmax_unit_pkg;

  localparam int unsigned TREE_IN_W       = 8;
  localparam int unsigned TREE_COEF_W     = 16;
  localparam int unsigned TREE_GROWTH_W   = 2;
  localparam int unsigned SCORE_W         = TREE_IN_W + TREE_COEF_W + TREE_GROWTH_W;
  localparam int unsigned TREE_LAT_DEF    = 8;
  localparam int unsigned NUM_CLASSES_DEF = 10;
  localparam int unsigned CLASS_IDX_W     = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } argmax_state_e;

endpackage : score_argmax_unit_pkg

// File: rtl/ff_reg_cell.sv
// Generic D flip-flop register cell with enable and synchronous active-low reset.
module ff_reg_cell #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : ff_reg_cell

// File: rtl/valid_delay_line.sv
// DEPTH-stage valid shift register built from register cells; DEPTH must be >= 1.
module valid_delay_line #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH:0] tap;

  assign tap[0] = in_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    ff_reg_cell #(.WIDTH(1)) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (1'b1),
      .d    (tap[i]),
      .q    (tap[i+1])
    );
  end

  assign out_valid = tap[DEPTH];

endmodule : valid_delay_line

// File: rtl/score_argmax_unit.sv
// Tracks the running maximum of the adder-tree scores of one frame and publishes
// the winning class index and score with a one-cycle Done pulse.
module score_argmax_unit
  import score_argmax_unit_pkg::*;
#(
  parameter int unsigned W           = SCORE_W,
  parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int unsigned TREE_LAT    = TREE_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   GlobalReset,
  input  logic                   InValid,
  input  logic [W-1:0]           Score,
  output logic [CLASS_IDX_W-1:0] ClassIdx,
  output logic [W-1:0]           MaxScore,
  output logic                   Done,
  output logic                   Busy
);

  localparam int unsigned      IDX_W    = CLASS_IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam bit               SINGLE   = (NUM_CLASSES < 2);

  logic             score_valid;
  argmax_state_e    state_q;
  argmax_state_e    state_d;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] run_idx_q;
  logic [W-1:0]     run_max_q;

  logic             is_first;
  logic [IDX_W-1:0] cur_idx;
  logic             take;
  logic             close_frame;

  // Aligns InValid with the adder-tree result.
  valid_delay_line #(.DEPTH(TREE_LAT)) u_valid_delay (
    .clk      (clk),
    .rst_n    (GlobalReset),
    .in_valid (InValid),
    .out_valid(score_valid)
  );

  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (score_valid && !SINGLE) state_d = ST_ACCUM;
      ST_ACCUM: if (score_valid && (cnt_q == LAST_IDX)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // In IDLE the arriving score is always class 0 of a new frame.
  always_comb begin
    is_first    = (state_q == ST_IDLE);
    cur_idx     = is_first ? '0 : cnt_q;
    take        = score_valid && (is_first || ($signed(Score) > $signed(run_max_q)));
    close_frame = score_valid && (is_first ? SINGLE : (cnt_q == LAST_IDX));
  end

  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      cnt_q     <= '0;
      run_idx_q <= '0;
      run_max_q <= '0;
      ClassIdx  <= '0;
      MaxScore  <= '0;
      Done      <= 1'b0;
    end else begin
      if (score_valid) begin
        cnt_q <= close_frame ? '0 : cur_idx + IDX_W'(1);
      end
      if (take) begin
        run_idx_q <= cur_idx;
        run_max_q <= Score;
      end
      // Final result folds in the closing score directly.
      if (close_frame) begin
        ClassIdx <= take ? cur_idx : run_idx_q;
        MaxScore <= take ? Score : run_max_q;
      end
      Done <= close_frame;
    end
  end

  assign Busy = (state_q == ST_ACCUM);

endmodule : score_argmax_unit

// File: tb/tb_score_argmax_unit.sv
// Randomized bench for score_argmax_unit with a frame-level argmax reference model
// and a cycle-indexed model of the adder tree feeding Score.
module tb_score_argmax_unit;

  localparam int unsigned W    = 26;
  localparam int unsigned NC   = 10;
  localparam int unsigned TL   = 8;
  localparam int          MAXC = 8192;

  typedef logic [W-1:0] frame_t [NC];

  typedef struct {
    int          cyc;
    logic [3:0]  idx;
    logic [W-1:0] mx;
  } exp_t;

  logic         clk = 1'b0;
  logic         GlobalReset;
  logic         InValid;
  logic [W-1:0] Score;
  logic [3:0]   ClassIdx;
  logic [W-1:0] MaxScore;
  logic         Done;
  logic         Busy;

  score_argmax_unit #(
    .W(W), .NUM_CLASSES(NC), .TREE_LAT(TL)
  ) dut (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .InValid    (InValid),
    .Score      (Score),
    .ClassIdx   (ClassIdx),
    .MaxScore   (MaxScore),
    .Done       (Done),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc      = 0;
  bit           sched_v [MAXC];
  logic [W-1:0] sched_s [MAXC];
  exp_t         exp_q[$];
  logic [W-1:0] fr [NC];
  int           fr_n    = 0;
  int           arrived = 0;
  logic [3:0]   exp_idx = '0;
  logic [W-1:0] exp_max = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, want, cyc);
    end
  endtask

  // Reference argmax: first index holding the largest signed score.
  function automatic void close_frame(input int in_cyc);
    exp_t e;
    int   best = 0;
    for (int i = 1; i < NC; i++) begin
      if ($signed(fr[i]) > $signed(fr[best])) best = i;
    end
    e.cyc = in_cyc + TL + 1;
    e.idx = 4'(best);
    e.mx  = fr[best];
    exp_q.push_back(e);
  endfunction

  task automatic step(input bit iv, input logic [W-1:0] s);
    bit arr;
    bit want_done;
    arr     = sched_v[cyc];
    InValid = iv;
    Score   = arr ? sched_s[cyc] : W'($urandom);
    if (iv) begin
      sched_v[cyc+TL] = 1'b1;
      sched_s[cyc+TL] = s;
      fr[fr_n] = s;
      fr_n++;
      if (fr_n == NC) begin
        close_frame(cyc);
        fr_n = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (arr && GlobalReset) arrived = (arrived + 1) % NC;
    want_done = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    if (want_done) begin
      exp_idx = exp_q[0].idx;
      exp_max = exp_q[0].mx;
      void'(exp_q.pop_front());
    end
    check_eq("done",      64'(Done),     64'(want_done));
    check_eq("class_idx", 64'(ClassIdx), 64'(exp_idx));
    check_eq("max_score", 64'(MaxScore), 64'(exp_max));
    check_eq("busy",      64'(Busy),     64'(arrived != 0));
  endtask

  task automatic do_reset(input int n);
    GlobalReset = 1'b0;
    for (int i = 0; i < MAXC; i++) sched_v[i] = 1'b0;
    exp_q.delete();
    fr_n    = 0;
    arrived = 0;
    exp_idx = '0;
    exp_max = '0;
    repeat (n) step(1'b0, '0);
    GlobalReset = 1'b1;
  endtask

  // Gap cycles go only between classes, so a following frame can abut this one.
  task automatic send_frame(input frame_t sc, input int gap);
    for (int i = 0; i < NC; i++) begin
      step(1'b1, sc[i]);
      if (i < NC - 1) repeat (gap) step(1'b0, '0);
    end
  endtask

  task automatic drain();
    repeat (TL + 3) step(1'b0, '0);
  endtask

  function automatic logic [W-1:0] rand_score(input bit narrow);
    int v;
    if (narrow) begin
      v = int'($urandom_range(16)) - 8;
      return W'(v);
    end
    return W'($urandom);
  endfunction

  initial begin
    frame_t f;
    frame_t g;
    GlobalReset = 1'b0;
    InValid     = 1'b0;
    Score       = '0;
    do_reset(3);

    for (int i = 0; i < NC; i++) f[i] = W'(i + 1);
    send_frame(f, 0);
    drain();

    for (int i = 0; i < NC; i++) f[i] = W'(-100);
    f[3] = W'(-5);
    send_frame(f, 0);
    drain();

    for (int i = 0; i < NC; i++) f[i] = '0;
    f[2] = W'(7);
    f[6] = W'(7);
    send_frame(f, 0);
    drain();

    for (int i = 0; i < NC; i++) f[i] = W'(int'($urandom_range(50)) - 25);
    for (int i = 0; i < NC; i++) g[i] = W'(int'($urandom_range(50)) - 25);
    send_frame(f, 1);
    send_frame(g, 0);
    drain();

    for (int i = 0; i < 5; i++) step(1'b1, W'(1000 + i));
    do_reset(2);
    for (int i = 0; i < NC; i++) f[i] = W'(i);
    f[4] = W'(500);
    send_frame(f, 0);
    drain();

    for (int k = 0; k < 150; k++) begin
      bit narrow;
      narrow = ($urandom_range(1) == 0);
      for (int i = 0; i < NC; i++) f[i] = rand_score(narrow);
      if (k == 70) begin
        for (int i = 0; i < 3; i++) step(1'b1, f[i]);
        do_reset(1 + int'($urandom_range(2)));
      end
      send_frame(f, int'($urandom_range(2)));
      repeat ($urandom_range(3)) step(1'b0, '0);
    end
    drain();

    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_score_argmax_unit
